// File: rtl/seg_display_ctrl_pkg.sv
// Shared constants for the hex display controller: segment width, the
// active-high gfedcba decode table and the polarity helper.
package seg_pkg;

    localparam int SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_OFF_AH = 7'h00;

    localparam logic [SEG_W-1:0] SEG_LUT_AH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [SEG_W-1:0] seg_apply_pol(
        input logic [SEG_W-1:0] pat_ah,
        input bit               active_low
    );
        return active_low ? ~pat_ah : pat_ah;
    endfunction

endpackage

// File: rtl/seg_hex_lut.sv
// Combinational nibble to active-high 7-segment pattern (gfedcba).
module seg_hex_lut
    import seg_pkg::*;
(
    input  logic [3:0]       nibble,
    output logic [SEG_W-1:0] pattern
);

    always_comb begin
        pattern = SEG_LUT_AH[nibble];
    end

endmodule

// File: rtl/seg_display_ctrl.sv
// Multi-digit hex display controller with leading-zero blanking, per-digit
// blinking and selectable polarity. Define SEG_SCAN_EN for a multiplexed scan output.
module seg_display_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_HZ     = 50_000_000,
    parameter int BLINK_HZ   = 2,
    parameter int ACTIVE_LOW = 1
`ifdef SEG_SCAN_EN
    ,
    parameter int SCAN_DIV   = 50_000
`endif
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        load,
    input  logic [4*NUM_DIGITS-1:0]     value,
    input  logic                        blank_lz,
    input  logic [NUM_DIGITS-1:0]       blink_mask,
`ifdef SEG_SCAN_EN
    output logic [SEG_W-1:0]            scan_seg,
    output logic [NUM_DIGITS-1:0]       scan_an,
`endif
    output logic [SEG_W*NUM_DIGITS-1:0] seg_out
);

    localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
    localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [SEG_W-1:0] OFF_PAT = (ACTIVE_LOW != 0) ? ~SEG_OFF_AH : SEG_OFF_AH;

    logic [4*NUM_DIGITS-1:0]     shadow_q, shadow_d;
    logic                        loaded_q, loaded_d;
    logic [CW-1:0]               blink_cnt_q, blink_cnt_d;
    logic                        phase_q, phase_d;
    logic [SEG_W*NUM_DIGITS-1:0] seg_out_q, seg_out_d;
    logic [NUM_DIGITS-1:0]       lz_blank;
    logic [SEG_W-1:0]            digit_pat [NUM_DIGITS];

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_lut
        seg_hex_lut u_lut (
            .nibble  (shadow_q[4*g +: 4]),
            .pattern (digit_pat[g])
        );
    end

    always_comb begin
        shadow_d    = load ? value : shadow_q;
        loaded_d    = loaded_q | load;
        blink_cnt_d = (blink_cnt_q == CW'(HALF - 1)) ? '0 : blink_cnt_q + 1'b1;
        phase_d     = phase_q ^ (blink_cnt_q == CW'(HALF - 1));
    end

    // Walk from the top digit down; a digit is leading-zero only while every nibble above it is zero.
    always_comb begin
        logic hi_zero;
        lz_blank = '0;
        hi_zero  = 1'b1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            hi_zero = hi_zero & (shadow_q[4*(NUM_DIGITS-1-i) +: 4] == 4'h0);
            if (i != NUM_DIGITS - 1) begin
                lz_blank[NUM_DIGITS-1-i] = blank_lz & hi_zero;
            end
        end
    end

    // Uses next-cycle phase so a toggle shows on the same edge the phase flop flips.
    always_comb begin
        seg_out_d = '0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (!loaded_q || lz_blank[k] || (phase_d && blink_mask[k])) begin
                seg_out_d[SEG_W*k +: SEG_W] = OFF_PAT;
            end else begin
                seg_out_d[SEG_W*k +: SEG_W] = seg_apply_pol(digit_pat[k], ACTIVE_LOW != 0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q    <= '0;
            loaded_q    <= 1'b0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            seg_out_q   <= {NUM_DIGITS{OFF_PAT}};
        end else begin
            shadow_q    <= shadow_d;
            loaded_q    <= loaded_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            seg_out_q   <= seg_out_d;
        end
    end

    assign seg_out = seg_out_q;

`ifdef SEG_SCAN_EN
    localparam int SDW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [SDW-1:0]        scan_cnt_q, scan_cnt_d;
    logic [IW-1:0]         scan_idx_q, scan_idx_d;
    logic                  scan_on_q, scan_on_d;
    logic                  scan_wrap;
    logic [NUM_DIGITS-1:0] an_onehot;

    // The first wrap only enables the anodes; the index starts advancing from the second.
    always_comb begin
        scan_wrap  = (scan_cnt_q == SDW'(SCAN_DIV - 1));
        scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + 1'b1;
        scan_on_d  = scan_on_q | scan_wrap;
        scan_idx_d = scan_idx_q;
        if (scan_wrap && scan_on_q) begin
            scan_idx_d = (scan_idx_q == IW'(NUM_DIGITS - 1)) ? '0 : scan_idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_q <= '0;
            scan_idx_q <= '0;
            scan_on_q  <= 1'b0;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            scan_idx_q <= scan_idx_d;
            scan_on_q  <= scan_on_d;
        end
    end

    always_comb begin
        an_onehot             = '0;
        an_onehot[scan_idx_q] = scan_on_q;
        scan_an               = (ACTIVE_LOW != 0) ? ~an_onehot : an_onehot;
        scan_seg              = seg_out_q[SEG_W*scan_idx_q +: SEG_W];
    end
`endif

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Scoreboard bench for seg_display_ctrl: 4 digits, active-low, HALF = 5 cycles.
module tb_seg_display_ctrl;

    localparam int ND   = 4;
    localparam int HALF = 5;
    localparam int SDIV = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load = 1'b0;
    logic [15:0]   value = '0;
    logic          blank_lz = 1'b0;
    logic [3:0]    blink_mask = '0;
    logic [27:0]   seg_out;
`ifdef SEG_SCAN_EN
    logic [6:0]    scan_seg;
    logic [3:0]    scan_an;
`endif

    seg_display_ctrl #(
        .NUM_DIGITS (ND),
        .CLK_HZ     (100),
        .BLINK_HZ   (10),
        .ACTIVE_LOW (1)
`ifdef SEG_SCAN_EN
        ,
        .SCAN_DIV   (SDIV)
`endif
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .value      (value),
        .blank_lz   (blank_lz),
        .blink_mask (blink_mask),
`ifdef SEG_SCAN_EN
        .scan_seg   (scan_seg),
        .scan_an    (scan_an),
`endif
        .seg_out    (seg_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [27:0] seg;
        int          e;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    logic [15:0] shadow_m = '0;
    bit          loaded_m = 1'b0;
    int          edges_m  = 0;
    logic [6:0]  pat_ah [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    task automatic check(input string name, input logic [27:0] act, input logic [27:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [27:0] model(input logic [15:0] sh, input bit loaded,
                                         input bit phase, input bit blz, input logic [3:0] bm);
        logic [27:0] r;
        r = '0;
        for (int k = 0; k < ND; k++) begin
            int  nib;
            bit  blank;
            nib   = (int'(sh) >> (4 * k)) & 15;
            blank = !loaded || (blz && k != 0 && (int'(sh) >> (4 * k)) == 0) || (phase && bm[k]);
            r[7*k +: 7] = blank ? 7'h7F : ~pat_ah[nib];
        end
        return r;
    endfunction

    // Drives one cycle of inputs at a falling edge and predicts seg_out after the next rising edge.
    task automatic step(input bit ld, input logic [15:0] val, input bit blz, input logic [3:0] bm);
        exp_t it;
        bit   phase;
        load = ld; value = val; blank_lz = blz; blink_mask = bm;
        edges_m++;
        phase  = ((edges_m / HALF) % 2) == 1;
        it.seg = model(shadow_m, loaded_m, phase, blz, bm);
        it.e   = edges_m;
        sb.push_back(it);
        if (ld) begin
            shadow_m = val;
            loaded_m = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic model_reset();
        shadow_m = '0;
        loaded_m = 1'b0;
        edges_m  = 0;
        sb.delete();
    endtask

    initial begin : monitor
        exp_t it;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && sb.size() > 0) begin
                it = sb.pop_front();
                check("seg_out", seg_out, it.seg);
`ifdef SEG_SCAN_EN
                begin
                    int         idx;
                    logic [3:0] an_exp;
                    idx    = (it.e >= SDIV) ? ((it.e / SDIV) - 1) % ND : 0;
                    an_exp = (it.e >= SDIV) ? ~(4'b0001 << idx) : 4'hF;
                    check("scan_an", 28'(scan_an), 28'(an_exp));
                    check("scan_seg", 28'(scan_seg), 28'(it.seg[7*idx +: 7]));
                end
`endif
            end
        end
    end

    initial begin : stim
        logic [15:0] v;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1 check("reset_state", seg_out, 28'hFFFFFFF);
        @(negedge clk);
        edges_m = 1;

        step(0, 16'h0000, 0, 4'b0000);
        step(1, 16'h1A3F, 0, 4'b0000);
        repeat (3) step(0, 16'h0000, 0, 4'b0000);
        step(1, 16'h0005, 1, 4'b0000);
        repeat (3) step(0, 16'h0000, 1, 4'b0000);
        step(1, 16'h0000, 1, 4'b0000);
        repeat (3) step(0, 16'h0000, 1, 4'b0000);
        step(0, 16'h0000, 0, 4'b0000);
        step(1, 16'h1234, 0, 4'b0001);
        repeat (20) step(0, 16'h0000, 0, 4'b0001);

        // Asynchronous reset between edges while a value is shown and blinking.
        #2 rst_n = 1'b0;
        #1 check("async_reset", seg_out, 28'hFFFFFFF);
        load = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("in_reset", seg_out, 28'hFFFFFFF);
        rst_n = 1'b1;
        step(0, 16'h0000, 0, 4'b0000);
        step(1, 16'hBEEF, 0, 4'b0000);
        repeat (4) step(0, 16'h0000, 0, 4'b0000);

        for (int n = 0; n < 400; n++) begin
            v = 16'($urandom);
            if ($urandom_range(0, 2) == 0) v = v >> (4 * $urandom_range(1, 4));
            step($urandom_range(0, 3) == 0, v, 1'($urandom), 4'($urandom));
        end

        load = 1'b0;
        repeat (3) @(negedge clk);
        check("sb_drain", 28'(sb.size()), 28'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_display_ctrl.md
Name: seg_display_ctrl

Overview:
Parametrised multi-digit hex display controller for DE2-class boards, the next generation of the single-digit hex-to-7-segment decoder. Latches a packed hex value on a load strobe and drives NUM_DIGITS registered 7-segment outputs. Adds leading-zero blanking, per-digit blinking and polarity selection. Sits between the UART RX/TX datapath and the board HEX displays.

Parameters:
NUM_DIGITS, 4, number of hex digits driven (1..8)
CLK_HZ, 50_000_000, clk frequency in Hz
BLINK_HZ, 2, blink frequency in Hz; half-period HALF = CLK_HZ/(2*BLINK_HZ) cycles, HALF >= 1
ACTIVE_LOW, 1, 1 = segment lit when bit is 0 (DE2); 0 = segment lit when bit is 1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
load  in  1  one-cycle strobe; latch value
value  in  4*NUM_DIGITS  packed nibbles; digit 0 = bits [3:0]
blank_lz  in  1  1 = blank leading zero digits
blink_mask  in  NUM_DIGITS  1 = digit blinks
seg_out  out  7*NUM_DIGITS  digit k on bits [7k+6:7k], bit order gfedcba

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: shadow register = 0, blink counter = 0, blink phase = 0. seg_out = all segments off (7'h7F per digit when ACTIVE_LOW=1, 7'h00 when ACTIVE_LOW=0).
- Latch: load=1 at edge N captures value into the shadow. seg_out reflects the new value at edge N+1, a 2-cycle load-to-display latency. load=0 holds the shadow.
- Inputs not latched: blank_lz and blink_mask are sampled combinationally each cycle and take effect on the next seg_out register update (1 cycle).
- Decode, active-high patterns in gfedcba order:
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
  - When ACTIVE_LOW=1, seg_out is the bitwise inverse of the pattern.
- Leading-zero blanking: with blank_lz=1, digit k is blanked iff its nibble and every higher nibble are zero. Digit 0 is never blanked by this rule, so value 0 shows a single "0".
- Blink counter:
  - Counts 0..HALF-1. On reaching HALF-1 it wraps to 0 and toggles phase.
  - Free-running; load does not reset it.
  - When phase=1, digits with blink_mask[k]=1 are blanked.
  - A digit is blanked if either the blanking rule or the blink rule applies.
- Simultaneous load and phase toggle: both take effect. The next seg_out uses the old shadow and the new phase. The cycle after uses the new shadow.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). Display is blank until the first load.

Optional Feature:
SEG_SCAN_EN
- Defined:
  - Adds outputs scan_seg (7 bits) and scan_an (NUM_DIGITS bits, one-hot, polarity per ACTIVE_LOW).
  - A scan counter advances the lit digit index every SCAN_DIV cycles (extra parameter, default 50_000), wrapping NUM_DIGITS-1 -> 0.
  - scan_seg carries the fully blanked/blinked pattern of the selected digit. On reset the index is 0 and scan_an is all-off for one SCAN_DIV period.
  - seg_out is still driven.
- Not defined: scan ports, scan logic and the SCAN_DIV parameter are absent.

Decomposition:
- Package seg_pkg:
  - SEG_W = 7
  - 16-entry active-high segment pattern constant array
  - SEG_OFF_AH = 7'h00
  - helper function for polarity apply
- Sub-module seg_hex_lut: combinational nibble-to-pattern lookup, instantiated NUM_DIGITS times with a generate loop.
- Counters, shadow register and output registers stay in the top module.

Test Plan:
1. Reset check: rst_n low then release, no load -> seg_out = 28'hFFFFFFF (NUM_DIGITS=4, ACTIVE_LOW=1).
2. Load and latency: load with value=16'h1A3F, blank_lz=0, blink_mask=0 -> two cycles later seg_out digits 3..0 = 79,08,30,0E (hex, active-low).
3. Leading-zero blanking: value=16'h0005, blank_lz=1 -> digits 3..1 = 7F, digit 0 = 12. Then value=16'h0000 -> digit 0 = 40, others 7F.
4. Blinking: CLK_HZ=100, BLINK_HZ=10, HALF=5, blink_mask=4'b0001, value=16'h1234 -> digit 0 alternates 19/7F every 5 cycles while digits 3..1 stay constant.
5. Mid-operation reset: assert rst_n asynchronously mid-blink with a value displayed -> seg_out = all 7F within the same cycle; a load after release restores the display with 2-cycle latency.
6. SEG_SCAN_EN with SCAN_DIV=3 -> scan_an cycles 1110,1101,1011,0111 every 3 cycles, and scan_seg matches the corresponding seg_out slice.
